// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: accepts a word over valid/ready and shifts it out
// as start, data (LSB first), optional parity and stop bits, one bit per baud_tick.
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Handshake: a word is taken on any rising edge where tx_valid=1 and tx_ready=1;
    // tx_ready is high only in IDLE, and tx_valid is ignored everywhere else.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int                CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS);
    localparam logic [1:0]        LAST_STOP = 2'(STOP_BITS);
    localparam logic              ODD_INV   = (PARITY_ODD != 0);
    localparam logic              HAS_PAR   = (PARITY_EN != 0);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]           stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 2'd0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // SYNC exists so the start bit always spans a full tick period, even when the
    // word arrives just before a tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (tx_valid) state_d = S_SYNC;
            S_SYNC:   if (baud_tick) state_d = S_START;
            S_START:  if (baud_tick) state_d = S_DATA;
            S_DATA: begin
                if (baud_tick && (bit_cnt_q == LAST_BIT)) begin
                    state_d = HAS_PAR ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (baud_tick) state_d = S_STOP;
            S_STOP:   if (baud_tick && (stop_cnt_q == LAST_STOP)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (tx_valid) begin
                    shift_d    = tx_data;
                    parity_d   = (^tx_data) ^ ODD_INV;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 2'd0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_SYNC: if (baud_tick) tx_d = 1'b0;
            S_START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (HAS_PAR) begin
                        tx_d = parity_q;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 2'd1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 2'd1;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    tx_d = 1'b1;
                    if (stop_cnt_q != LAST_STOP) begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four framing configurations driven in lockstep, checked
// against a tick-counting frame model and a line decoder with a per-instance queue.
module tb_uart_tx_ctrl;

    localparam int NI = 4;

    logic          clk;
    logic          rst;
    logic          baud_tick;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic [NI-1:0] tx_ready_w;
    logic [NI-1:0] tx_w;
    logic [NI-1:0] tx_busy_w;
    logic [NI-1:0] tx_done_w;

    // (parity_en, parity_odd, stop_bits): u0=(0,0,1) u1=(1,0,1) u2=(1,1,2) u3=(0,0,2)
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_w[0]), .tx(tx_w[0]), .tx_busy(tx_busy_w[0]), .tx_done(tx_done_w[0]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_w[1]), .tx(tx_w[1]), .tx_busy(tx_busy_w[1]), .tx_done(tx_done_w[1]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_w[2]), .tx(tx_w[2]), .tx_busy(tx_busy_w[2]), .tx_done(tx_done_w[2]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_w[3]), .tx(tx_w[3]), .tx_busy(tx_busy_w[3]), .tx_done(tx_done_w[3]));

    function automatic int cfg_pe(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_po(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_sb(input int i);
        return (i >= 2) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return 1 + 8 + cfg_pe(i) + cfg_sb(i);
    endfunction

    // Line bits in transmit order: bit 0 is the start bit.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int i);
        logic [15:0] f;
        int          idx;
        f = '0;
        for (int b = 0; b < 8; b++) f[1 + b] = d[b];
        idx = 9;
        if (cfg_pe(i) != 0) begin
            f[idx] = (^d) ^ (cfg_po(i) != 0);
            idx++;
        end
        for (int s = 0; s < cfg_sb(i); s++) f[idx + s] = 1'b1;
        return f;
    endfunction

    // ---------------- clock / tick generation ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tick_div;
    int tick_cnt;
    initial begin
        baud_tick = 1'b0;
        tick_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt  = (tick_cnt + 1) % tick_div;
            baud_tick = (tick_cnt == 0);
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int          n_cmp;
    int          n_err;
    int          to_cnt;
    bit          fin_req;
    bit          fin_ack;
    logic [15:0] exp_q[NI][$];
    bit          busy_m[NI];
    int          left_m[NI];
    logic [15:0] dec_bits[NI];
    int          dec_n[NI];
    bit          dec_on[NI];
    logic        tx_prev[NI];
    logic        rst_s, tick_s, valid_s;
    logic [7:0]  data_s;

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d: got %0h, want %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic mon_edge(input int i);
        bit          was_busy;
        bit          exp_done;
        bit          accept;
        logic [15:0] exp_f;
        if (!rst_s) begin
            check("rst_tx", i, tx_w[i], 1);
            check("rst_ready", i, tx_ready_w[i], 1);
            check("rst_busy", i, tx_busy_w[i], 0);
            check("rst_done", i, tx_done_w[i], 0);
            busy_m[i] = 1'b0;
            left_m[i] = 0;
            exp_q[i].delete();
            dec_on[i] = 1'b0;
            dec_n[i]  = 0;
        end else begin
            was_busy = busy_m[i];
            exp_done = 1'b0;
            if (was_busy && tick_s) begin
                left_m[i]--;
                if (left_m[i] == 0) begin
                    busy_m[i] = 1'b0;
                    exp_done  = 1'b1;
                end
            end
            accept = valid_s && !was_busy;
            if (accept) begin
                exp_q[i].push_back(frame_bits(data_s, i));
                busy_m[i] = 1'b1;
                left_m[i] = frame_len(i) + 1;
            end
            check("done", i, tx_done_w[i], exp_done);
            check("ready", i, tx_ready_w[i], !busy_m[i]);
            check("busy", i, tx_busy_w[i], busy_m[i]);
            if (!busy_m[i] || accept) check("tx_idle", i, tx_w[i], 1);
            if (!tick_s) check("tx_hold", i, tx_w[i], tx_prev[i]);

            if (tx_done_w[i]) begin
                if (dec_on[i] && tick_s) begin
                    check("frame_present", i, exp_q[i].size() > 0, 1);
                    if (exp_q[i].size() > 0) begin
                        exp_f = exp_q[i].pop_front();
                        check("frame_len", i, dec_n[i], frame_len(i));
                        check("frame_bits", i, dec_bits[i], exp_f);
                    end
                end else begin
                    check("done_aligned", i, 0, 1);
                end
                dec_on[i] = 1'b0;
            end else if (tick_s) begin
                if (dec_on[i]) begin
                    if (dec_n[i] < frame_len(i)) begin
                        dec_bits[i][dec_n[i]] = tx_w[i];
                        dec_n[i]++;
                    end else begin
                        check("frame_overrun", i, dec_n[i] + 1, frame_len(i));
                        dec_on[i] = 1'b0;
                        if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
                    end
                end else if (tx_w[i] == 1'b0) begin
                    dec_on[i]   = 1'b1;
                    dec_bits[i] = '0;
                    dec_n[i]    = 1;
                end
            end
        end
        tx_prev[i] = tx_w[i];
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        fin_ack = 1'b0;
        rst_s   = 1'b0;
        tick_s  = 1'b0;
        valid_s = 1'b0;
        data_s  = '0;
        for (int i = 0; i < NI; i++) begin
            busy_m[i]   = 1'b0;
            left_m[i]   = 0;
            dec_bits[i] = '0;
            dec_n[i]    = 0;
            dec_on[i]   = 1'b0;
            tx_prev[i]  = 1'b1;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) mon_edge(i);
            rst_s   = rst;
            tick_s  = baud_tick;
            valid_s = tx_valid;
            data_s  = tx_data;
            if (fin_req && !fin_ack) begin
                for (int i = 0; i < NI; i++) check("queue_empty", i, exp_q[i].size(), 0);
                check("timeouts", 0, to_cnt, 0);
                fin_ack = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (!((&tx_ready_w) && !(|tx_busy_w)) && n < max_cyc) begin
            step();
            n++;
        end
        if (n >= max_cyc) to_cnt++;
    endtask

    task automatic align_tick();
        int n;
        n = 0;
        while (!baud_tick && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic poke_while_busy();
        repeat (3) step();
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        repeat (5) step();
        tx_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        tick_div = 4;
        to_cnt   = 0;
        fin_req  = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        repeat (12) step();

        send(8'hA5);
        wait_idle(400);
        send(8'h00);
        wait_idle(400);

        align_tick();
        send(8'h96);
        wait_idle(400);

        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        repeat (20) step();
        tx_data = 8'hFF;
        repeat (45) step();
        tx_valid = 1'b0;
        wait_idle(400);

        send(8'h55);
        n = 0;
        for (int g = 0; g < 200 && n < 5; g++) begin
            step();
            if (baud_tick) n++;
        end
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (3) step();
        send(8'h55);
        wait_idle(400);

        for (int k = 0; k < 24; k++) begin
            tick_div = $urandom_range(2, 6);
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 3) == 0) align_tick();
            send(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) poke_while_busy();
            wait_idle(500);
        end

        repeat (5) step();
        fin_req = 1'b1;
        for (int g = 0; g < 10 && !fin_ack; g++) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
